// File: rtl/dmem_master.sv
// -----------------------------------------------------------------------------
// dmem_master
//
// Bridges a single-outstanding CPU load/store request onto a simple
// ce/ready data-memory port. The request is checked for natural alignment,
// then either answered immediately with a misalign fault, or turned into one
// registered memory access that is held until mem_ready arrives or a cycle
// budget of TIMEOUT runs out. Load data is lane-selected and sign/zero
// extended. Stores return zero.
//
// Parameters
//   TIMEOUT       maximum cycles mem_ce stays high waiting for mem_ready
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_*         CPU request (valid, we, size, unsigned, addr, wdata)
//   busy          CPU stall: in ACCESS, and in IDLE while req_valid is high
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores and faults)
//   misalign      alignment fault, qualified by resp_valid
//   timeout_err   no-ready fault, qualified by resp_valid
//   mem_ce/we/addr/wr_data/byte_sel   registered memory request
//   mem_rd_data, mem_ready            memory response
// -----------------------------------------------------------------------------
module dmem_master #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_sel,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ready
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    state_t            r_state,        w_state_next;
    logic [CntW-1:0]   r_count,        w_count_next;
    logic              r_mem_ce,       w_mem_ce_next;
    logic              r_mem_we,       w_mem_we_next;
    logic [31:0]       r_mem_addr,     w_mem_addr_next;
    logic [31:0]       r_mem_wr_data,  w_mem_wr_data_next;
    logic [3:0]        r_mem_byte_sel, w_mem_byte_sel_next;
    logic [1:0]        r_size,         w_size_next;
    logic              r_unsigned,     w_unsigned_next;
    logic              r_we,           w_we_next;
    logic [1:0]        r_lane,         w_lane_next;
    logic [31:0]       r_rdata,        w_rdata_next;
    logic              r_misalign,     w_misalign_next;
    logic              r_timeout,      w_timeout_next;

    logic              w_busy;
    logic              w_misaligned;
    logic [3:0]        w_req_byte_sel;
    logic [31:0]       w_req_wr_data;
    logic [31:0]       w_rd_shift;
    logic [31:0]       w_load_data;

    // ---------------------------------------------------------------------
    // Request decode (combinational on the live request inputs)
    // ---------------------------------------------------------------------
    always_comb begin
        w_misaligned   = 1'b0;
        w_req_byte_sel = 4'b1111;
        w_req_wr_data  = req_wdata;
        case (req_size)
            2'b00: begin
                w_req_byte_sel = 4'b0001 << req_addr[1:0];
                w_req_wr_data  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned   = req_addr[0];
                w_req_byte_sel = 4'b0011 << {req_addr[1], 1'b0};
                w_req_wr_data  = {2{req_wdata[15:0]}};
            end
            default: begin
                // 2'b11 behaves as a word access.
                w_misaligned   = (req_addr[1:0] != 2'b00);
                w_req_byte_sel = 4'b1111;
                w_req_wr_data  = req_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Load lane extraction. Accesses are aligned, so shifting by lane*8
    // brings the addressed byte or halfword down to bit 0 in both cases.
    // ---------------------------------------------------------------------
    always_comb begin
        w_rd_shift  = mem_rd_data >> {r_lane, 3'b000};
        w_load_data = mem_rd_data;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01:   w_load_data = {{16{~r_unsigned & w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_load_data = mem_rd_data;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_count        <= '0;
            r_mem_ce       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wr_data  <= '0;
            r_mem_byte_sel <= '0;
            r_size         <= '0;
            r_unsigned     <= 1'b0;
            r_we           <= 1'b0;
            r_lane         <= '0;
            r_rdata        <= '0;
            r_misalign     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_count        <= w_count_next;
            r_mem_ce       <= w_mem_ce_next;
            r_mem_we       <= w_mem_we_next;
            r_mem_addr     <= w_mem_addr_next;
            r_mem_wr_data  <= w_mem_wr_data_next;
            r_mem_byte_sel <= w_mem_byte_sel_next;
            r_size         <= w_size_next;
            r_unsigned     <= w_unsigned_next;
            r_we           <= w_we_next;
            r_lane         <= w_lane_next;
            r_rdata        <= w_rdata_next;
            r_misalign     <= w_misalign_next;
            r_timeout      <= w_timeout_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        w_count_next        = r_count;
        w_mem_ce_next       = r_mem_ce;
        w_mem_we_next       = r_mem_we;
        w_mem_addr_next     = r_mem_addr;
        w_mem_wr_data_next  = r_mem_wr_data;
        w_mem_byte_sel_next = r_mem_byte_sel;
        w_size_next         = r_size;
        w_unsigned_next     = r_unsigned;
        w_we_next           = r_we;
        w_lane_next         = r_lane;
        w_rdata_next        = r_rdata;
        w_misalign_next     = r_misalign;
        w_timeout_next      = r_timeout;
        w_busy              = 1'b0;

        case (r_state)
            StIdle: begin
                w_busy = req_valid;
                if (req_valid) begin
                    w_size_next     = req_size;
                    w_unsigned_next = req_unsigned;
                    w_we_next       = req_we;
                    w_lane_next     = req_addr[1:0];
                    w_rdata_next    = '0;
                    w_timeout_next  = 1'b0;
                    if (w_misaligned) begin
                        // Fault without touching memory.
                        w_misalign_next = 1'b1;
                        w_state_next    = StResp;
                    end else begin
                        w_misalign_next     = 1'b0;
                        w_count_next        = '0;
                        w_mem_ce_next       = 1'b1;
                        w_mem_we_next       = req_we;
                        w_mem_addr_next     = {req_addr[31:2], 2'b00};
                        w_mem_wr_data_next  = w_req_wr_data;
                        w_mem_byte_sel_next = w_req_byte_sel;
                        w_state_next        = StAccess;
                    end
                end
            end

            StAccess: begin
                w_busy = 1'b1;
                if (mem_ready || (r_count == CntW'(TIMEOUT - 1))) begin
                    // Either way the access ends: drop the whole memory request.
                    w_mem_ce_next       = 1'b0;
                    w_mem_we_next       = 1'b0;
                    w_mem_addr_next     = '0;
                    w_mem_wr_data_next  = '0;
                    w_mem_byte_sel_next = '0;
                    w_count_next        = '0;
                    w_state_next        = StResp;
                    if (mem_ready) begin
                        w_rdata_next = r_we ? 32'h0 : w_load_data;
                    end else begin
                        w_timeout_next = 1'b1;
                        w_rdata_next   = '0;
                    end
                end else begin
                    w_count_next = r_count + CntW'(1);
                end
            end

            StResp: begin
                // Response lasts one cycle; clear it so outputs idle at zero.
                w_rdata_next    = '0;
                w_misalign_next = 1'b0;
                w_timeout_next  = 1'b0;
                w_state_next    = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // busy is combinational from req_valid; hold it low while rst is asserted.
    assign busy         = w_busy & ~rst;
    assign resp_valid   = (r_state == StResp);
    assign resp_rdata   = r_rdata;
    assign misalign     = r_misalign;
    assign timeout_err  = r_timeout;
    assign mem_ce       = r_mem_ce;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_byte_sel = r_mem_byte_sel;

endmodule

// File: tb/tb_dmem_master.sv
// -----------------------------------------------------------------------------
// tb_dmem_master
//
// Directed and randomized load/store accesses against dmem_master. A memory
// responder pulses mem_ready two cycles after each ce rise (or never, for
// timeout cases). Expected values come from a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_master;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;
    logic        timeout_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_sel;
    logic [31:0] mem_rd_data;
    logic        mem_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder control.
    bit          rsp_enable = 1'b1;
    logic [31:0] rsp_word   = 32'h0;

    dmem_master #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .misalign    (misalign),
        .timeout_err (timeout_err),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_byte_sel(mem_byte_sel),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Memory responder: ready two cycles after it sees a ce rise; rd_data is
    // junk on every other cycle so that sampling in the wrong cycle shows up.
    initial begin : responder
        int   pend;
        logic prev_ce;
        pend        = 0;
        prev_ce     = 1'b0;
        mem_ready   = 1'b0;
        mem_rd_data = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready   = 1'b0;
            mem_rd_data = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ready   = 1'b1;
                    mem_rd_data = rsp_word;
                end
            end
            if (mem_ce && !prev_ce && rsp_enable) pend = 2;
            prev_ce = mem_ce;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     {31'b0, busy},        32'h0);
        check({tag, "_rvalid"},   {31'b0, resp_valid},  32'h0);
        check({tag, "_rdata"},    resp_rdata,           32'h0);
        check({tag, "_flags"},    {30'b0, misalign, timeout_err}, 32'h0);
        check({tag, "_ce_we"},    {30'b0, mem_ce, mem_we}, 32'h0);
        check({tag, "_addr"},     mem_addr,             32'h0);
        check({tag, "_wr"},       mem_wr_data,          32'h0);
        check({tag, "_sel"},      {28'b0, mem_byte_sel}, 32'h0);
    endtask

    // One complete CPU access with reference-model expectations.
    task automatic run_access(input string tag, input bit we, input logic [1:0] size,
                              input bit uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input bit ready_on);
        int          n, off, k, ce_cycles, exp_lat, exp_ce;
        bit          misal, got, hold_ok;
        logic [31:0] exp_sel, exp_wr, exp_load, exp_rd;
        logic [31:0] got_rdata, got_flags, got_busy;

        // Reference model: n-byte access at byte offset off within the word.
        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        misal = (off % n) != 0;
        exp_sel = (((32'd1 << n) - 1) << off) & 32'hF;
        for (int i = 0; i < 4; i++) exp_wr[8*i +: 8] = wdata[8*(i % n) +: 8];
        exp_load = 32'h0;
        if (!misal) begin
            for (int i = 0; i < n; i++) exp_load[8*i +: 8] = rdata[8*(off + i) +: 8];
            if (!uns && exp_load[8*n-1])
                for (int i = n; i < 4; i++) exp_load[8*i +: 8] = 8'hFF;
        end
        exp_rd  = (misal || we || !ready_on) ? 32'h0 : exp_load;
        exp_lat = misal ? 1 : (ready_on ? 4 : int'(TIMEOUT) + 1);
        exp_ce  = misal ? 0 : (ready_on ? 3 : int'(TIMEOUT));

        rsp_enable = ready_on;
        rsp_word   = rdata;

        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
        check({tag, "_ce_low_before"}, {31'b0, mem_ce}, 32'h0);
        check({tag, "_busy_req"},      {31'b0, busy},   32'h1);

        k = 0; ce_cycles = 0; hold_ok = 1'b1; got = 1'b0;
        got_rdata = '0; got_flags = '0; got_busy = '0;
        while (!got && k < int'(TIMEOUT) + 10) begin
            @(negedge clk); #1;
            k++;
            if (mem_ce) begin
                ce_cycles++;
                if (ce_cycles == 1) begin
                    check({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                    check({tag, "_mem_sel"},  {28'b0, mem_byte_sel}, exp_sel);
                    check({tag, "_mem_we"},   {31'b0, mem_we}, {31'b0, we});
                    if (we) check({tag, "_mem_wr"}, mem_wr_data, exp_wr);
                end else if (mem_addr !== (addr & 32'hFFFF_FFFC) ||
                             {28'b0, mem_byte_sel} !== exp_sel || mem_we !== we ||
                             (we && mem_wr_data !== exp_wr)) begin
                    hold_ok = 1'b0;
                end
            end
            if (resp_valid) begin
                got       = 1'b1;
                got_rdata = resp_rdata;
                got_flags = {30'b0, misalign, timeout_err};
                got_busy  = {31'b0, busy};
            end
        end
        req_valid = 1'b0;

        check({tag, "_resp_seen"}, {31'b0, got}, 32'h1);
        check({tag, "_latency"},   k, exp_lat);
        check({tag, "_ce_cycles"}, ce_cycles, exp_ce);
        check({tag, "_hold"},      {31'b0, hold_ok}, 32'h1);
        check({tag, "_rdata"},     got_rdata, exp_rd);
        check({tag, "_flags"},     got_flags, {30'b0, misal, (!misal && !ready_on)});
        check({tag, "_busy_resp"}, got_busy, 32'h0);
        check({tag, "_ce_in_resp"}, {31'b0, mem_ce}, 32'h0);
    endtask

    initial begin : main
        int rv_seen, ce_seen;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Directed accesses.
        run_access("lw_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        run_access("lb_13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80FF_FF7F, 1'b1);
        run_access("lbu_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80FF_FF7F, 1'b1);
        run_access("sh_22",   1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h5555_AAAA, 1'b1);
        run_access("lh_22",   1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h8001_7FFF, 1'b1);
        run_access("lhu_20",  1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h8001_F00F, 1'b1);
        run_access("lw_06",   1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h1111_1111, 1'b1);
        run_access("lh_odd",  1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 32'h1111_1111, 1'b1);
        run_access("sz11_w",  1'b0, 2'b11, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b1);
        run_access("tmo",     1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h2222_2222, 1'b0);
        // Back-to-back store then load.
        run_access("b2b_sw",  1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A5_5A5A, 32'h0, 1'b1);
        run_access("b2b_lw",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0BAD_CAFE, 1'b1);

        // Reset in the middle of an access: dropped, no response; the late
        // ready pulse lands in IDLE and must be ignored.
        rsp_enable = 1'b1;
        rsp_word   = 32'h7777_7777;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;
        check_all_zero("mid_rst");
        rst = 1'b0;
        rv_seen = 0; ce_seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (resp_valid) rv_seen++;
            if (mem_ce) ce_seen++;
        end
        check("mid_rst_no_resp", rv_seen, 0);
        check("mid_rst_no_ce",   ce_seen, 0);
        run_access("post_rst", 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h0000_8000, 1'b1);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            run_access($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                       $urandom, $urandom, $urandom, ($urandom % 8) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
